// File: rtl/baccarat_pkg.sv
// -----------------------------------------------------------------------------
// baccarat_pkg
// Shared definitions for the baccarat round sequencer:
//   - state_e            : sequencer state encoding (also exported on state_dbg)
//   - CARD_*             : 4-bit card codes driven by the datapath
//   - NATURAL_MIN_DEFAULT: two-card score at or above which a hand is a natural
//   - sat_score()        : clamps a score input to the legal 0-9 range
//   - card_value()       : baccarat point value of a card code
// Optional feature macro used by importers: BACCARAT_BETTING_EN
// -----------------------------------------------------------------------------
package baccarat_pkg;

   typedef enum logic [3:0] {
      ST_BET    = 4'd0,
      ST_P1     = 4'd1,
      ST_D1     = 4'd2,
      ST_P2     = 4'd3,
      ST_D2     = 4'd4,
      ST_EVAL   = 4'd5,
      ST_P3     = 4'd6,
      ST_EVAL_D = 4'd7,
      ST_D3     = 4'd8,
      ST_RESULT = 4'd9,
      ST_PAY    = 4'd10,
      ST_DONE   = 4'd11
   } state_e;

   localparam logic [3:0] CARD_EMPTY = 4'd0;
   localparam logic [3:0] CARD_ACE   = 4'd1;
   localparam logic [3:0] CARD_TEN   = 4'd10;
   localparam logic [3:0] CARD_JACK  = 4'd11;
   localparam logic [3:0] CARD_QUEEN = 4'd12;
   localparam logic [3:0] CARD_KING  = 4'd13;

   localparam int unsigned NATURAL_MIN_DEFAULT = 8;
   localparam logic [3:0]  SCORE_MAX           = 4'd9;

   // Out-of-range scores from the datapath are read as the maximum score.
   function automatic logic [3:0] sat_score(input logic [3:0] score);
      return (score > SCORE_MAX) ? SCORE_MAX : score;
   endfunction

   // Ten and the face cards count zero; empty and illegal codes count zero.
   function automatic logic [3:0] card_value(input logic [3:0] code);
      if (code < CARD_ACE || code > CARD_KING)
         return CARD_EMPTY;
      else if (code inside {CARD_TEN, CARD_JACK, CARD_QUEEN, CARD_KING})
         return 4'd0;
      else
         return code;
   endfunction

endpackage

// File: rtl/baccarat_sequencer_banker_draw_rule.sv
// -----------------------------------------------------------------------------
// banker_draw_rule
// Combinational banker third-card rule, evaluated once the player has drawn.
// Ports:
//   i_dscore [3:0] : banker two-card score (values above 9 read as 9)
//   i_pcard3 [3:0] : player third-card code (10-13 count as 0)
//   o_draw         : 1 = banker takes a third card, 0 = banker stands
// -----------------------------------------------------------------------------
module banker_draw_rule
   import baccarat_pkg::*;
(
   input  logic [3:0] i_dscore,
   input  logic [3:0] i_pcard3,
   output logic       o_draw
);

   logic [3:0] w_dscore;
   logic [3:0] w_cval;

   assign w_dscore = sat_score(i_dscore);
   assign w_cval   = card_value(i_pcard3);

   always_comb begin
      // NOTE: default assignment first so no path through the case leaves
      // o_draw unassigned, which would otherwise infer a latch.
      o_draw = 1'b0;
      case (w_dscore)
         4'd0, 4'd1, 4'd2: o_draw = 1'b1;
         4'd3:             o_draw = (w_cval != 4'd8);
         4'd4:             o_draw = (w_cval >= 4'd2) && (w_cval <= 4'd7);
         4'd5:             o_draw = (w_cval >= 4'd4) && (w_cval <= 4'd7);
         4'd6:             o_draw = (w_cval >= 4'd6) && (w_cval <= 4'd7);
         default:          o_draw = 1'b0;
      endcase
   end

endmodule

// File: rtl/baccarat_sequencer.sv
// -----------------------------------------------------------------------------
// baccarat_sequencer
// Control FSM for one baccarat round: deals two cards each, applies the
// natural / player / banker drawing rules, latches the result lights and,
// when betting is built in, strobes the bet and balance registers.
// Configuration macro: BACCARAT_BETTING_EN (defined = BET and PAY states).
// Ports:
//   clock, resetb          : slow datapath clock, async active-low reset
//   pscore, dscore [3:0]   : hand scores from the datapath (0-9)
//   pcard3 [3:0]           : player third-card code (0 = empty)
//   load_pcard1..3,
//   load_dcard1..3         : card-register load strobes
//   betenabled             : bet-register load strobe
//   updatebalanceenable    : balance-register load strobe
//   player_win, dealer_win : result lights (both high on a tie)
//   round_done             : high while in DONE
//   state_dbg [3:0]        : current state encoding
// -----------------------------------------------------------------------------
module baccarat_sequencer
   import baccarat_pkg::*;
#(
   parameter int unsigned NATURAL_MIN = NATURAL_MIN_DEFAULT
)(
   input  logic       clock,
   input  logic       resetb,
   input  logic [3:0] pscore,
   input  logic [3:0] dscore,
   input  logic [3:0] pcard3,
   output logic       load_pcard1,
   output logic       load_pcard2,
   output logic       load_pcard3,
   output logic       load_dcard1,
   output logic       load_dcard2,
   output logic       load_dcard3,
   output logic       betenabled,
   output logic       updatebalanceenable,
   output logic       player_win,
   output logic       dealer_win,
   output logic       round_done,
   output logic [3:0] state_dbg
);

   localparam logic [3:0] LP_NATURAL = 4'(NATURAL_MIN);
   localparam logic [3:0] LP_DRAW_MAX = 4'd5;

`ifdef BACCARAT_BETTING_EN
   localparam state_e LP_RESET_STATE = ST_BET;
`else
   localparam state_e LP_RESET_STATE = ST_P1;
`endif

   state_e     r_state;
   logic       r_player_win;
   logic       r_dealer_win;
   logic       r_round_done;

   logic [3:0] w_pscore;
   logic [3:0] w_dscore;
   logic       w_banker_draw;

   assign w_pscore = sat_score(pscore);
   assign w_dscore = sat_score(dscore);

   banker_draw_rule u_banker_draw_rule (
      .i_dscore (dscore),
      .i_pcard3 (pcard3),
      .o_draw   (w_banker_draw)
   );

   always_ff @(posedge clock or negedge resetb) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples the pre-edge values, independent of statement order.
      if (!resetb) begin
         r_state      <= LP_RESET_STATE;
         r_player_win <= 1'b0;
         r_dealer_win <= 1'b0;
         r_round_done <= 1'b0;
      end else begin
         case (r_state)
`ifdef BACCARAT_BETTING_EN
            ST_BET:    r_state <= ST_P1;
`endif
            ST_P1:     r_state <= ST_D1;
            ST_D1:     r_state <= ST_P2;
            ST_P2:     r_state <= ST_D2;
            ST_D2:     r_state <= ST_EVAL;
            ST_EVAL: begin
               if (w_pscore >= LP_NATURAL || w_dscore >= LP_NATURAL)
                  r_state <= ST_RESULT;
               else if (w_pscore <= LP_DRAW_MAX)
                  r_state <= ST_P3;
               else if (w_dscore <= LP_DRAW_MAX)
                  r_state <= ST_D3;
               else
                  r_state <= ST_RESULT;
            end
            ST_P3:     r_state <= ST_EVAL_D;
            ST_EVAL_D: r_state <= w_banker_draw ? ST_D3 : ST_RESULT;
            ST_D3:     r_state <= ST_RESULT;
            ST_RESULT: begin
               // Lights are written only here, so they hold until reset.
               r_player_win <= (w_pscore >= w_dscore);
               r_dealer_win <= (w_dscore >= w_pscore);
`ifdef BACCARAT_BETTING_EN
               r_state      <= ST_PAY;
`else
               r_state      <= ST_DONE;
               r_round_done <= 1'b1;
`endif
            end
`ifdef BACCARAT_BETTING_EN
            ST_PAY: begin
               r_state      <= ST_DONE;
               r_round_done <= 1'b1;
            end
`endif
            ST_DONE:   r_state <= ST_DONE;
            default:   r_state <= LP_RESET_STATE;
         endcase
      end
   end

   // Strobes decode the state directly so each load lands on the edge that
   // leaves its state, one edge before the next scoring state samples.
   // Gating with resetb keeps the reset state's strobe quiet while reset is
   // held; it fires in the first cycle after release.
   always_comb begin
      load_pcard1         = 1'b0;
      load_pcard2         = 1'b0;
      load_pcard3         = 1'b0;
      load_dcard1         = 1'b0;
      load_dcard2         = 1'b0;
      load_dcard3         = 1'b0;
      betenabled          = 1'b0;
      updatebalanceenable = 1'b0;
      if (resetb) begin
         case (r_state)
`ifdef BACCARAT_BETTING_EN
            ST_BET:  betenabled          = 1'b1;
            ST_PAY:  updatebalanceenable = 1'b1;
`endif
            ST_P1:   load_pcard1 = 1'b1;
            ST_D1:   load_dcard1 = 1'b1;
            ST_P2:   load_pcard2 = 1'b1;
            ST_D2:   load_dcard2 = 1'b1;
            ST_P3:   load_pcard3 = 1'b1;
            ST_D3:   load_dcard3 = 1'b1;
            default: ;
         endcase
      end
   end

   assign player_win = r_player_win;
   assign dealer_win = r_dealer_win;
   assign round_done = r_round_done;
   assign state_dbg  = r_state;

endmodule

// File: doc/baccarat_sequencer.md
BACCARAT_SEQUENCER -- requirements
Module: baccarat_sequencer

Interface
REQ-001 Parameter NATURAL_MIN, default 8: two-card score at or above which a hand is a natural.
REQ-002 clock  input  1  state-advance clock, rising edge; the datapath's slow clock.
REQ-003 resetb  input  1  reset, asynchronous, active-low.
REQ-004 pscore  input  4  player hand score from datapath, 0-9.
REQ-005 dscore  input  4  dealer hand score from datapath, 0-9.
REQ-006 pcard3  input  4  player third-card code from datapath, 0-13; 0 means empty.
REQ-007 load_pcard1/2/3, load_dcard1/2/3  output  1 each  card-register load strobes.
REQ-008 betenabled  output  1  bet-register load strobe.
REQ-009 updatebalanceenable  output  1  balance-register load strobe.
REQ-010 player_win, dealer_win  output  1 each  result lights; both high on a tie.
REQ-011 round_done  output  1  high while in DONE.
REQ-012 state_dbg  output  4  current state encoding.

Function
REQ-013 States: BET, P1, D1, P2, D2, EVAL, P3, EVAL_D, D3, RESULT, PAY, DONE; one transition per clock edge.
REQ-014 Strobes are Moore decodes of the state, at most one high per cycle: BET->betenabled, P1->load_pcard1, D1->load_dcard1, P2->load_pcard2, D2->load_dcard2, P3->load_pcard3, D3->load_dcard3, PAY->updatebalanceenable.
REQ-015 Fixed order: BET->P1->D1->P2->D2->EVAL; P3->EVAL_D; D3->RESULT; RESULT->PAY->DONE.
REQ-016 EVAL: pscore>=NATURAL_MIN or dscore>=NATURAL_MIN -> RESULT; else pscore<=5 -> P3; else dscore<=5 -> D3; else -> RESULT.
REQ-017 EVAL_D banker rule, c = pcard3 value with codes 10-13 counted as 0: dscore 0-2 draw; 3 draw unless c==8; 4 draw if c in 2-7; 5 draw if c in 4-7; 6 draw if c in 6-7; 7 stand. Draw -> D3; stand -> RESULT.
REQ-018 Scores are sampled only in EVAL, EVAL_D and RESULT, each at least one edge after the last load, so the datapath register latency is covered.
REQ-019 RESULT edge registers player_win=(pscore>=dscore) and dealer_win=(dscore>=pscore); the lights hold until reset.
REQ-020 DONE is absorbing; only resetb starts a new round.
REQ-021 Score inputs above 9 are treated as 9.

Reset
REQ-022 resetb low asynchronously forces state BET (P1 when BETTING_EN is undefined), all strobes 0, player_win=0, dealer_win=0, round_done=0.
REQ-023 Reset asserted mid-round aborts the round; no strobe pulses after reset assertion.

Configuration
REQ-024 Macro BACCARAT_BETTING_EN defined: BET and PAY states exist as specified.
REQ-025 BACCARAT_BETTING_EN undefined: BET and PAY are removed; reset enters P1; RESULT->DONE; betenabled and updatebalanceenable are tied 0.

Structure
REQ-026 Shared package baccarat_pkg holds the state enum, the 4-bit card-code constants (ACE=1, JACK..KING=11..13) and NATURAL_MIN default.
REQ-027 Sub-module banker_draw_rule (combinational: dscore, pcard3 -> draw) implements REQ-017 and is reused by the bench as reference.

Verification
REQ-028 Natural: two-card pscore=8, dscore=3 -> EVAL->RESULT; no load_pcard3/load_dcard3 pulse; player_win=1, dealer_win=0.
REQ-029 Player draws, banker stands: pscore=4, dscore=6, pcard3=5 (c=5) -> P3, EVAL_D->RESULT, load_dcard3 never pulses.
REQ-030 Banker-3 exception: dscore=3, pcard3=8 -> stand; repeat with pcard3=9 -> D3 pulse one cycle.
REQ-031 Player stands 7, dscore=5 -> EVAL->D3->RESULT; tie 7/7 -> player_win=1 and dealer_win=1.
REQ-032 Strobe check over a full round: exactly one betenabled, one updatebalanceenable, never two strobes high in the same cycle; resetb pulsed in P2 -> state BET asynchronously, all outputs 0.
REQ-033 Build without BACCARAT_BETTING_EN: reset->P1, betenabled and updatebalanceenable constant 0, RESULT->DONE in one edge.
